// File: rtl/edge_gen_pkg.sv
// Shared types and sizing helper for the edge generator slice.
package edge_gen_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    HOLD_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    HOLD_LOW  = 2'd3
  } edge_gen_state_e;

  // Counter must hold max(MIN_HIGH, MIN_LOW) - 1; sized one larger for headroom.
  function automatic int cnt_width(input int min_high, input int min_low);
    int m;
    m = (min_high > min_low) ? min_high : min_low;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/min_width_counter.sv
// Loadable down-counter that saturates at zero; done_o flags the final hold cycle.
module min_width_counter #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic          done_o
);

  logic [CW-1:0] r_cnt;

  // Load wins over decrement; never wraps below zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                r_cnt <= '0;
    else if (load_i)          r_cnt <= load_val_i;
    else if (r_cnt != '0)     r_cnt <= r_cnt - CW'(1);
  end

  assign done_o = (r_cnt == '0);

endmodule

// File: rtl/edge_generator.sv
// Turns rise/fall request pulses into a level with enforced minimum high/low widths.
// One opposite-edge request may be parked while a minimum width is served.
module edge_generator
  import edge_gen_pkg::*;
#(
  parameter logic RESET_LEVEL = 1'b0,
  parameter int   MIN_HIGH    = 3,
  parameter int   MIN_LOW     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic rise_req_i,
  input  logic fall_req_i,
  output logic a_o,
  output logic busy_o,
  output logic pend_o,
  output logic drop_o
);

  localparam int CW = cnt_width(MIN_HIGH, MIN_LOW);
  localparam logic [CW-1:0] LOAD_HIGH = CW'(MIN_HIGH - 1);
  localparam logic [CW-1:0] LOAD_LOW  = CW'(MIN_LOW - 1);
  localparam edge_gen_state_e RST_STATE = RESET_LEVEL ? IDLE_HIGH : IDLE_LOW;

  edge_gen_state_e r_state;
  logic            r_a;
  logic            r_busy;
  logic            r_pend;
  logic            r_drop;

  logic            w_rise;
  logic            w_fall;
  logic            w_both;
  logic            w_done;
  logic            w_load;
  logic [CW-1:0]   w_load_val;

  // Simultaneous rise+fall is treated as a conflict and discarded as a whole.
  assign w_rise = rise_req_i & ~fall_req_i;
  assign w_fall = fall_req_i & ~rise_req_i;
  assign w_both = rise_req_i &  fall_req_i;

  // Counter load whenever a new hold begins (from idle or on hold exit).
  always_comb begin
    w_load     = 1'b0;
    w_load_val = LOAD_HIGH;
    case (r_state)
      IDLE_LOW:  if (w_rise) begin
                   w_load = 1'b1; w_load_val = LOAD_HIGH;
                 end
      IDLE_HIGH: if (w_fall) begin
                   w_load = 1'b1; w_load_val = LOAD_LOW;
                 end
      HOLD_HIGH: if (w_done && (r_pend || w_fall)) begin
                   w_load = 1'b1; w_load_val = LOAD_LOW;
                 end
      HOLD_LOW:  if (w_done && (r_pend || w_rise)) begin
                   w_load = 1'b1; w_load_val = LOAD_HIGH;
                 end
      default:   ;
    endcase
  end

  min_width_counter #(.CW(CW)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (w_load),
    .load_val_i (w_load_val),
    .done_o     (w_done)
  );

  // Main FSM; a_o/busy_o are registered alongside the state, not decoded from it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RST_STATE;
      r_a     <= RESET_LEVEL;
      r_busy  <= 1'b0;
      r_pend  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_drop <= 1'b0;
      case (r_state)
        IDLE_LOW: begin
          if (w_both) r_drop <= 1'b1;
          else if (w_rise) begin
            r_state <= HOLD_HIGH;
            r_a     <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        IDLE_HIGH: begin
          if (w_both) r_drop <= 1'b1;
          else if (w_fall) begin
            r_state <= HOLD_LOW;
            r_a     <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        HOLD_HIGH: begin
          // Only one opposite request can be parked; extras and conflicts are dropped.
          if (w_both || (w_fall && r_pend)) r_drop <= 1'b1;
          if (w_done) begin
            r_pend <= 1'b0;
            if (r_pend || w_fall) begin
              r_state <= HOLD_LOW;
              r_a     <= 1'b0;
            end else begin
              r_state <= IDLE_HIGH;
              r_busy  <= 1'b0;
            end
          end else if (w_fall) begin
            r_pend <= 1'b1;
          end
        end
        HOLD_LOW: begin
          if (w_both || (w_rise && r_pend)) r_drop <= 1'b1;
          if (w_done) begin
            r_pend <= 1'b0;
            if (r_pend || w_rise) begin
              r_state <= HOLD_HIGH;
              r_a     <= 1'b1;
            end else begin
              r_state <= IDLE_LOW;
              r_busy  <= 1'b0;
            end
          end else if (w_rise) begin
            r_pend <= 1'b1;
          end
        end
        default: begin
          r_state <= RST_STATE;
          r_a     <= RESET_LEVEL;
          r_busy  <= 1'b0;
          r_pend  <= 1'b0;
        end
      endcase
    end
  end

  assign a_o    = r_a;
  assign busy_o = r_busy;
  assign pend_o = r_pend;
  assign drop_o = r_drop;

endmodule

// File: tb/tb_edge_generator.sv
// Scoreboard bench for edge_generator (MIN_HIGH=3, MIN_LOW=2, RESET_LEVEL=0).
module tb_edge_generator;

  localparam int MH = 3;
  localparam int ML = 2;

  typedef struct packed {
    logic a;
    logic busy;
    logic pend;
    logic drop;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rise_req_i = 1'b0;
  logic fall_req_i = 1'b0;
  logic a_o, busy_o, pend_o, drop_o;

  always #5 clk = ~clk;

  edge_generator #(.RESET_LEVEL(1'b0), .MIN_HIGH(MH), .MIN_LOW(ML)) dut (
    .clk        (clk),
    .reset      (reset),
    .rise_req_i (rise_req_i),
    .fall_req_i (fall_req_i),
    .a_o        (a_o),
    .busy_o     (busy_o),
    .pend_o     (pend_o),
    .drop_o     (drop_o)
  );

  int n_err = 0;
  int n_chk = 0;
  obs_t exp_q[$];

  // Behavioural reference: level plus cycles remaining in the current hold.
  bit m_a, m_busy, m_pend, m_drop;
  int m_left;

  // Downstream edge detector on a_o, reset together with the DUT.
  logic ed_prev;
  int   n_rise = 0;
  int   n_fall = 0;
  always @(posedge clk or posedge reset) begin
    if (reset) ed_prev <= 1'b0;
    else begin
      ed_prev <= a_o;
      if (a_o && !ed_prev) n_rise <= n_rise + 1;
      if (!a_o && ed_prev) n_fall <= n_fall + 1;
    end
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_a = 1'b0; m_busy = 1'b0; m_pend = 1'b0; m_drop = 1'b0; m_left = 0;
  endtask

  task automatic model_step(input bit r, input bit f);
    bit opp, same;
    m_drop = 1'b0;
    if (!m_busy) begin
      if (r && f) m_drop = 1'b1;
      else if (r && !m_a) begin m_a = 1'b1; m_left = MH; m_busy = 1'b1; end
      else if (f && m_a)  begin m_a = 1'b0; m_left = ML; m_busy = 1'b1; end
    end else begin
      opp  = m_a ? f : r;
      same = m_a ? r : f;
      if ((r && f) || (opp && m_pend)) m_drop = 1'b1;
      if (m_left == 1) begin
        if (m_pend || (opp && !same)) begin
          m_a    = ~m_a;
          m_left = m_a ? MH : ML;
        end else begin
          m_busy = 1'b0;
        end
        m_pend = 1'b0;
      end else begin
        m_left--;
        if (opp && !same) m_pend = 1'b1;
      end
    end
  endtask

  // Drive one cycle of requests, predict, then compare just after the edge.
  task automatic cycle(input bit r, input bit f);
    obs_t e;
    rise_req_i = r;
    fall_req_i = f;
    model_step(r, f);
    e.a = m_a; e.busy = m_busy; e.pend = m_pend; e.drop = m_drop;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("a_o",    int'(a_o),    int'(e.a));
    chk("busy_o", int'(busy_o), int'(e.busy));
    chk("pend_o", int'(pend_o), int'(e.pend));
    chk("drop_o", int'(drop_o), int'(e.drop));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
  endtask

  int r0, f0;

  initial begin
    // 1: reset held two cycles, then quiet
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("rst_a", int'(a_o), 0);
      chk("rst_busy", int'(busy_o), 0);
      chk("rst_pend", int'(pend_o), 0);
      chk("rst_drop", int'(drop_o), 0);
    end
    reset = 1'b0;
    idle(5);

    // 2: single rise pulse -> exactly MIN_HIGH busy cycles, one rising edge
    r0 = n_rise;
    cycle(1'b1, 1'b0);
    chk("s2_a_up", int'(a_o), 1);
    idle(2);
    chk("s2_busy_last", int'(busy_o), 1);
    idle(1);
    chk("s2_idle_high", int'(busy_o), 0);
    chk("s2_still_high", int'(a_o), 1);
    idle(2);
    chk("s2_one_rise", n_rise - r0, 1);
    cycle(1'b0, 1'b1);
    idle(3);

    // 3: rise then fall one cycle later -> fall parked, a_o high exactly MIN_HIGH
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    chk("s3_pend", int'(pend_o), 1);
    idle(1);
    chk("s3_a_c13", int'(a_o), 1);
    idle(1);
    chk("s3_a_c14", int'(a_o), 0);
    chk("s3_busy_c14", int'(busy_o), 1);
    idle(1);
    chk("s3_busy_c15", int'(busy_o), 1);
    idle(2);

    // 4: second fall while one is parked -> single drop pulse
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    chk("s4_drop", int'(drop_o), 1);
    idle(1);
    chk("s4_drop_once", int'(drop_o), 0);
    chk("s4_a_c14", int'(a_o), 0);
    idle(3);

    // 5: conflicting requests in IDLE_LOW
    cycle(1'b1, 1'b1);
    chk("s5_a", int'(a_o), 0);
    chk("s5_drop", int'(drop_o), 1);
    idle(2);

    // random traffic against the reference model
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);

    // settle to IDLE_LOW
    cycle(1'b0, 1'b1);
    idle(5);
    cycle(1'b0, 1'b1);
    idle(5);

    // 6: async reset mid-HOLD_HIGH with a parked fall
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    chk("s6_pend_before", int'(pend_o), 1);
    reset = 1'b1;
    #1;
    chk("s6_async_a", int'(a_o), 0);
    chk("s6_async_pend", int'(pend_o), 0);
    chk("s6_async_busy", int'(busy_o), 0);
    rise_req_i = 1'b0;
    fall_req_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    f0 = n_fall;
    r0 = n_rise;
    idle(6);
    chk("s6_no_fall", n_fall - f0, 0);
    chk("s6_no_rise", n_rise - r0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
